// File: rtl/dp_min_select_pkg.sv
// Shared types and constants for the dynamic-programming minimum selector.
package dp_min_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_I         = 160;

  // Saturation bounds for the default cost width.
  localparam logic signed [DEF_BIT_WIDTH-1:0] DEF_SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [DEF_BIT_WIDTH-1:0] DEF_SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/dp_min_select_if.sv
// Row-control, Emin stream, cost-memory and result-write signals of dp_min_select.
interface dp_min_select_if
  import dp_min_select_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int I         = DEF_I
) ();
  localparam int IW = $clog2(I);

  logic                        start_in;
  logic [IW-1:0]               i_in;
  logic                        emin_valid_in;
  logic [IW-1:0]               j_in;
  logic signed [BIT_WIDTH-1:0] emin_in;
  logic [IW-1:0]               cost_req_out;
  logic signed [BIT_WIDTH-1:0] cost_resp_in;
  logic                        wr_en_out;
  logic [IW-1:0]               wr_addr_out;
  logic signed [BIT_WIDTH-1:0] cost_wr_out;
  logic [IW-1:0]               ptr_wr_out;
  logic                        busy_out;

  modport master (
    output start_in, i_in, emin_valid_in, j_in, emin_in, cost_resp_in,
    input  cost_req_out, wr_en_out, wr_addr_out, cost_wr_out, ptr_wr_out, busy_out
  );

  modport slave (
    input  start_in, i_in, emin_valid_in, j_in, emin_in, cost_resp_in,
    output cost_req_out, wr_en_out, wr_addr_out, cost_wr_out, ptr_wr_out, busy_out
  );
endinterface

// File: rtl/dp_min_select_sat_add.sv
// Combinational signed 3-input adder with two guard bits, clamped to the W-bit range.
module sat_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  output logic signed [W-1:0] y
);
  localparam logic signed [W+1:0] MAX_EXT = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MIN_EXT = {3'b111, {(W-1){1'b0}}};

  logic signed [W+1:0] sum_s;

  // Wide sum followed by clamp to the representable range.
  always_comb begin
    sum_s = W'(0) + {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + {{2{c[W-1]}}, c};
    if (sum_s > MAX_EXT) begin
      y = MAX_EXT[W-1:0];
    end else if (sum_s < MIN_EXT) begin
      y = MIN_EXT[W-1:0];
    end else begin
      y = sum_s[W-1:0];
    end
  end
endmodule

// File: rtl/dp_min_select.sv
// One DP row: F(i) = min over received j of F(j-1) + Emin(j,i) + SEG_PENALTY, with argmin backpointer.
module dp_min_select
  import dp_min_select_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int I         = DEF_I,
  parameter logic signed [BIT_WIDTH-1:0] SEG_PENALTY = '0
) (
  input logic             clk_in,
  input logic             rst_in,
  dp_min_select_if.slave  bus
);
  localparam int IW = $clog2(I);
  localparam logic [IW-1:0]               ONE_IDX  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic signed [BIT_WIDTH-1:0] MAX_COST = {1'b0, {(BIT_WIDTH-1){1'b1}}};

  state_t                      state_r, state_s;
  logic                        accept_s;
  logic [IW-1:0]               i_r;
  logic                        v1_r, v2_r, v3_r;
  logic [IW-1:0]               j1_r, j2_r, j3_r;
  logic signed [BIT_WIDTH-1:0] e1_r, e2_r, sum3_r;
  logic signed [BIT_WIDTH-1:0] prev_cost_s, cand_s;
  logic signed [BIT_WIDTH-1:0] best_r;
  logic [IW-1:0]               best_j_r;
  logic                        wr_en_r, busy_r;
  logic [IW-1:0]               wr_addr_r, ptr_wr_r;
  logic signed [BIT_WIDTH-1:0] cost_wr_r;

  assign bus.cost_req_out = bus.j_in - ONE_IDX;
  assign bus.wr_en_out    = wr_en_r;
  assign bus.busy_out     = busy_r;
  assign bus.wr_addr_out  = wr_addr_r;
  assign bus.cost_wr_out  = cost_wr_r;
  assign bus.ptr_wr_out   = ptr_wr_r;

  // The j=0 segment starts at the origin, so its memory response is never used.
  assign prev_cost_s = (j2_r == '0) ? '0 : bus.cost_resp_in;

  sat_add #(.W(BIT_WIDTH)) u_sat_add (
    .a (prev_cost_s),
    .b (e2_r),
    .c (SEG_PENALTY),
    .y (cand_s)
  );

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and sample acceptance.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_in) state_s = ST_ACCUM;
        else              state_s = ST_IDLE;
      end
      ST_ACCUM: begin
        accept_s = bus.emin_valid_in && (bus.j_in <= i_r);
        if (accept_s && (bus.j_in == i_r)) state_s = ST_DRAIN;
        else                               state_s = ST_ACCUM;
      end
      ST_DRAIN: begin
        if (!(v1_r || v2_r || v3_r)) state_s = ST_WRITE;
        else                         state_s = ST_DRAIN;
      end
      ST_WRITE: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Capture -> delay -> sum -> compare pipeline and running minimum.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      i_r      <= '0;
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      v3_r     <= 1'b0;
      j1_r     <= '0;
      j2_r     <= '0;
      j3_r     <= '0;
      e1_r     <= '0;
      e2_r     <= '0;
      sum3_r   <= '0;
      best_r   <= MAX_COST;
      best_j_r <= '0;
    end else begin
      v1_r   <= accept_s;
      j1_r   <= bus.j_in;
      e1_r   <= bus.emin_in;
      v2_r   <= v1_r;
      j2_r   <= j1_r;
      e2_r   <= e1_r;
      v3_r   <= v2_r;
      j3_r   <= j2_r;
      sum3_r <= cand_s;
      if ((state_r == ST_IDLE) && bus.start_in) begin
        i_r      <= bus.i_in;
        best_r   <= MAX_COST;
        best_j_r <= '0;
      end else if (v3_r && (sum3_r < best_r)) begin
        best_r   <= sum3_r;
        best_j_r <= j3_r;
      end
    end
  end

  // Registered result port and busy flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      wr_addr_r <= '0;
      cost_wr_r <= '0;
      ptr_wr_r  <= '0;
    end else begin
      wr_en_r <= (state_s == ST_WRITE);
      busy_r  <= (state_s != ST_IDLE);
      if (state_s == ST_WRITE) begin
        wr_addr_r <= i_r;
        cost_wr_r <= best_r;
        ptr_wr_r  <= best_j_r;
      end
    end
  end
endmodule
